// File: rtl/emu_clock_pkg.sv
// Shared types and helpers for the emulated-clock tick scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package emu_clock_pkg;

  // Widest ps quantity the helper below handles; also the default TIME_WIDTH.
  localparam int DEF_TIME_WIDTH = 64;

  typedef logic [DEF_TIME_WIDTH-1:0] ps_t;

  // WAIT counts down to the next edge, FIRE holds a due edge until it retires.
  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_FIRE = 1'b1
  } state_e;

  // a - b clamped at zero; an advance can never drive time-to-edge negative.
  function automatic ps_t sat_sub(input ps_t a, input ps_t b);
    return (b >= a) ? '0 : (a - b);
  endfunction

endpackage

// File: rtl/emu_cycle_counter.sv
// Counts retired modeled-clock edges; free-running 64-bit wrap counter.
// Latency: count reflects an enable one host cycle later.
// Backpressure: none; increments on every enabled cycle.
module emu_cycle_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [63:0] count
);

  // Synchronous clear, natural wrap from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/emu_clock_tick.sv
// Tick scheduler for one modeled DUT clock: turns ps time advances into edge enables.
// Latency: an advance reaching the edge gives ff/ram enables the next host cycle.
// Backpressure: adv_ready drops while an edge is pending; stall/run_en hold the edge.
// Optional: define EMU_CLOCK_CYCLE_CNT_EN to add the 64-bit cycle_count output.
// TIME_WIDTH may be at most emu_clock_pkg::DEF_TIME_WIDTH (64).
module emu_clock_tick
  import emu_clock_pkg::*;
#(
  parameter longint unsigned CYCLE_PERIOD_PS = 10000,
  parameter longint unsigned PHASE_SHIFT_PS  = 0,
  parameter int              TIME_WIDTH      = DEF_TIME_WIDTH
) (
  input  logic                  host_clk,
  input  logic                  host_rstn,
  input  logic                  run_en,
  input  logic                  stall,
  input  logic                  adv_valid,
  input  logic [TIME_WIDTH-1:0] adv_ps,
  output logic                  adv_ready,
  output logic [TIME_WIDTH-1:0] next_edge_ps,
  output logic                  ff_clk_en,
  output logic                  ram_clk_en,
  output logic                  overshoot_err
`ifdef EMU_CLOCK_CYCLE_CNT_EN
  ,
  output logic [63:0]           cycle_count
`endif
);

  // No edge at t=0: a zero phase means the first edge is one full period out.
  localparam logic [TIME_WIDTH-1:0] PERIOD = TIME_WIDTH'(CYCLE_PERIOD_PS);
  localparam logic [TIME_WIDTH-1:0] RESET_REMAIN =
    (PHASE_SHIFT_PS == 0) ? TIME_WIDTH'(CYCLE_PERIOD_PS) : TIME_WIDTH'(PHASE_SHIFT_PS);

  state_e                  state;
  logic [TIME_WIDTH-1:0]   remain;
  logic [TIME_WIDTH-1:0]   remain_sub;
  logic                    adv_take;
  logic                    adv_hits_edge;
  logic                    adv_overshoots;
  logic                    fire_active;

  // Advance bookkeeping and edge outputs. Enables are masked during reset so a
  // pending edge is dropped silently rather than pulsing in the reset cycle.
  always_comb begin
    fire_active    = (state == S_FIRE);
    adv_ready      = !fire_active;
    adv_take       = adv_valid && !fire_active;
    adv_hits_edge  = (adv_ps >= remain);
    adv_overshoots = (adv_ps > remain);
    remain_sub     = TIME_WIDTH'(sat_sub(ps_t'(remain), ps_t'(adv_ps)));
    next_edge_ps   = fire_active ? '0 : remain;
    ram_clk_en     = fire_active && run_en && host_rstn;
    ff_clk_en      = ram_clk_en && !stall;
  end

  // Countdown / fire sequencing; the overshoot flag is sticky until reset.
  always_ff @(posedge host_clk) begin
    if (!host_rstn) begin
      state         <= S_WAIT;
      remain        <= RESET_REMAIN;
      overshoot_err <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (adv_take) begin
            remain <= remain_sub;
            if (adv_hits_edge) begin
              state <= S_FIRE;
            end
            if (adv_overshoots) begin
              overshoot_err <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (ff_clk_en) begin
            state  <= S_WAIT;
            remain <= PERIOD;
          end
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

`ifdef EMU_CLOCK_CYCLE_CNT_EN
  emu_cycle_counter u_cycle_counter (
    .clk   (host_clk),
    .rstn  (host_rstn),
    .en    (ff_clk_en),
    .count (cycle_count)
  );
`endif

endmodule
